// File: rtl/axis_resp_arbiter.sv
// axis_resp_arbiter
//   Round-robin, packet-locked arbiter that merges NUM_PORTS AXI-Stream
//   response streams into one stream toward the SPI bridge (MISO side).
//   The IDLE state picks the next requester. The LOCKED state connects the
//   owner straight through until it sends a tlast beat, or until the
//   watchdog releases a stalled owner.
//
// Parameters
//   NUM_PORTS      number of requesters (2..8)
//   DATA_WIDTH     byte lane width
//   TIMEOUT_CYCLES stall limit while LOCKED; 0 removes the watchdog
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   s_axis_t*            per-port slave streams; port i data is
//                        s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_t*            merged master stream
//   grant                registered one-hot owner, zero when idle
//   busy                 high while LOCKED
//   timeout_pulse        one-cycle pulse when the watchdog forces a release
module axis_resp_arbiter #(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
  output logic [NUM_PORTS-1:0]            s_axis_tready,
  input  logic [NUM_PORTS-1:0]            s_axis_tlast,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic                            timeout_pulse
);

  localparam int PTR_W = (NUM_PORTS > 2) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] last_ptr;
  logic [PTR_W-1:0] owner;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_vld;
  logic             beat;
  logic             beat_last;
  logic             timeout;

  // Round-robin search starting one past the previous owner. The sum is one
  // bit wider than the pointer so the wrap works for any port count,
  // including non-powers of two.
  always_comb begin : rr_pick
    logic [PTR_W:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = {1'b0, last_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_PORTS)) begin
        cand = cand - (PTR_W+1)'(NUM_PORTS);
      end
      if (!pick_vld && s_axis_tvalid[cand[PTR_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[PTR_W-1:0];
      end
    end
  end

  // Pass-through path: the owner's inputs reach the output combinationally,
  // so the first beat can transfer on the first LOCKED cycle.
  always_comb begin
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    if (state == LOCKED) begin
      m_axis_tdata         = s_axis_tdata[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
      m_axis_tvalid        = s_axis_tvalid[owner];
      m_axis_tlast         = s_axis_tlast[owner];
      s_axis_tready[owner] = m_axis_tready;
    end
  end

  assign beat      = (state == LOCKED) && m_axis_tvalid && m_axis_tready;
  assign beat_last = beat && m_axis_tlast;

  // Watchdog: counts LOCKED cycles without a beat. It fires on the edge
  // where the count would reach TIMEOUT_CYCLES. Any beat in that cycle
  // suppresses it, so a tlast beat always wins the tie.
  if (TIMEOUT_CYCLES > 0) begin : g_wdog
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wd_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wd_cnt <= '0;
      end else if (state == IDLE) begin
        if (pick_vld) begin
          wd_cnt <= '0;
        end
      end else if (beat) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
    end

    assign timeout = (state == LOCKED) && !beat &&
                     (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  end else begin : g_no_wdog
    assign timeout = 1'b0;
  end

  // Control FSM: state, owner and pointer are all registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      busy          <= 1'b0;
      grant         <= '0;
      owner         <= '0;
      last_ptr      <= PTR_W'(NUM_PORTS - 1);
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            state <= LOCKED;
            busy  <= 1'b1;
            owner <= pick_idx;
            grant <= NUM_PORTS'(1) << pick_idx;
          end
        end
        LOCKED: begin
          if (beat_last) begin
            state    <= IDLE;
            busy     <= 1'b0;
            grant    <= '0;
            last_ptr <= owner;
          end else if (timeout) begin
            state         <= IDLE;
            busy          <= 1'b0;
            grant         <= '0;
            last_ptr      <= owner;
            timeout_pulse <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_resp_arbiter.sv
// Directed bench for axis_resp_arbiter. Three instances share the stimulus:
// dut (TIMEOUT_CYCLES=8), dut4 (TIMEOUT_CYCLES=4) and dut0 (watchdog absent).
// Each cycle runs from one negedge to the next. Inputs change at the negedge,
// outputs are sampled 1 ns later, and the active posedge follows.
module tb_axis_resp_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [NP*DW-1:0] s_tdata;
  logic [NP-1:0]    s_tvalid;
  logic [NP-1:0]    s_tlast;
  logic             m_tready;

  logic [NP-1:0] s_tready,  grant;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid,  m_tlast,  busy,  tpulse;
  logic [NP-1:0] s_tready4, grant4;
  logic [DW-1:0] m_tdata4;
  logic          m_tvalid4, m_tlast4, busy4, tpulse4;
  logic [NP-1:0] s_tready0, grant0;
  logic [DW-1:0] m_tdata0;
  logic          m_tvalid0, m_tlast0, busy0, tpulse0;

  int errors = 0;
  int checks = 0;

  axis_resp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .grant(grant),
    .busy(busy), .timeout_pulse(tpulse)
  );

  axis_resp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4),
    .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast4), .grant(grant4),
    .busy(busy4), .timeout_pulse(tpulse4)
  );

  axis_resp_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready0),
    .s_axis_tlast(s_tlast), .m_axis_tdata(m_tdata0), .m_axis_tvalid(m_tvalid0),
    .m_axis_tready(m_tready), .m_axis_tlast(m_tlast0), .grant(grant0),
    .busy(busy0), .timeout_pulse(tpulse0)
  );

  task automatic clear_inputs();
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    m_tready = 1'b0;
  endtask

  task automatic set_port(input int p, input logic [7:0] d, input logic v, input logic l);
    s_tdata[p*DW +: DW] = d;
    s_tvalid[p]         = v;
    s_tlast[p]          = l;
  endtask

  // Ends on a negedge with reset released and all inputs idle.
  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    set_port(3, 8'h33, 1'b1, 1'b1);
    m_tready = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", grant); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00) begin errors++; $display("FAIL reset_mout: got v=%b l=%b d=%h want 0/0/00", m_tvalid, m_tlast, m_tdata); end
    checks++; if (s_tready !== 4'b0000) begin errors++; $display("FAIL reset_sready: got %b want 0000", s_tready); end
    checks++; if (tpulse !== 1'b0) begin errors++; $display("FAIL reset_tpulse: got %b want 0", tpulse); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_hold_grant: got %b want 0000", grant); end
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 8'h30, 1'b1, 1'b1);
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_no_early_arb: got %b want 0000", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL reset_first_port0: got %b want 0001", grant); end
    checks++; if (m_tdata !== 8'h30) begin errors++; $display("FAIL reset_first_data: got %h want 30", m_tdata); end
  endtask

  task automatic test_single();
    apply_reset();
    set_port(2, 8'hA1, 1'b1, 1'b0);
    m_tready = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL single_idle: got g=%b v=%b want 0000/0", grant, m_tvalid); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", grant); end
    checks++; if (m_tdata !== 8'hA1 || m_tvalid !== 1'b1 || m_tlast !== 1'b0) begin errors++; $display("FAIL single_b1: got d=%h v=%b l=%b want A1/1/0", m_tdata, m_tvalid, m_tlast); end
    checks++; if (s_tready !== 4'b0100) begin errors++; $display("FAIL single_sready: got %b want 0100", s_tready); end
    @(negedge clk);
    set_port(2, 8'hA2, 1'b1, 1'b0);
    #1;
    checks++; if (m_tdata !== 8'hA2 || m_tvalid !== 1'b1 || m_tlast !== 1'b0) begin errors++; $display("FAIL single_b2: got d=%h v=%b l=%b want A2/1/0", m_tdata, m_tvalid, m_tlast); end
    @(negedge clk);
    set_port(2, 8'hA3, 1'b1, 1'b1);
    #1;
    checks++; if (m_tdata !== 8'hA3 || m_tvalid !== 1'b1 || m_tlast !== 1'b1) begin errors++; $display("FAIL single_b3: got d=%h v=%b l=%b want A3/1/1", m_tdata, m_tvalid, m_tlast); end
    @(negedge clk);
    set_port(2, 8'h00, 1'b0, 1'b0);
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL single_release: got g=%b busy=%b want 0000/0", grant, busy); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    logic [7:0] exp_d [10] = '{8'h00, 8'h10, 8'h00, 8'h11, 8'h00, 8'h12, 8'h00, 8'h13, 8'h00, 8'h10};
    apply_reset();
    set_port(0, 8'h10, 1'b1, 1'b1);
    set_port(1, 8'h11, 1'b1, 1'b1);
    set_port(2, 8'h12, 1'b1, 1'b1);
    set_port(3, 8'h13, 1'b1, 1'b1);
    m_tready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++; if (grant !== exp_g[c]) begin errors++; $display("FAIL rr_grant c%0d: got %b want %b", c, grant, exp_g[c]); end
      checks++; if (m_tdata !== exp_d[c]) begin errors++; $display("FAIL rr_data c%0d: got %h want %h", c, m_tdata, exp_d[c]); end
    end
    clear_inputs();
  endtask

  task automatic test_lock_backpressure();
    logic [7:0] exp_b;
    apply_reset();
    set_port(0, 8'hB0, 1'b1, 1'b0);
    set_port(1, 8'hC0, 1'b1, 1'b1);
    m_tready = 1'b0;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL lock_idle: got %b want 0000", grant); end
    // Ready toggles 1,0,1,0,... so the four beats land on cycles 1,3,5,7.
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_b = 8'(8'hB0 + (c - 1) / 2);
      set_port(0, exp_b, 1'b1, ((c - 1) / 2) == 3);
      m_tready = (c % 2) == 1;
      #1;
      checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL lock_grant c%0d: got %b want 0001", c, grant); end
      checks++; if (m_tdata !== exp_b) begin errors++; $display("FAIL lock_data c%0d: got %h want %h", c, m_tdata, exp_b); end
      checks++; if (s_tready !== {3'b000, m_tready}) begin errors++; $display("FAIL lock_sready c%0d: got %b want %b", c, s_tready, {3'b000, m_tready}); end
    end
    checks++; if (m_tlast !== 1'b1) begin errors++; $display("FAIL lock_tlast: got %b want 1", m_tlast); end
    @(negedge clk);
    set_port(0, 8'h00, 1'b0, 1'b0);
    m_tready = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000 || m_tvalid !== 1'b0) begin errors++; $display("FAIL lock_gap: got g=%b v=%b want 0000/0", grant, m_tvalid); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0010 || m_tdata !== 8'hC0) begin errors++; $display("FAIL lock_port1: got g=%b d=%h want 0010/C0", grant, m_tdata); end
    clear_inputs();
  endtask

  task automatic test_watchdog();
    apply_reset();
    set_port(3, 8'h3D, 1'b1, 1'b0);
    m_tready = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL wd_idle: got %b want 0000", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b1000 || m_tdata !== 8'h3D || m_tvalid !== 1'b1) begin errors++; $display("FAIL wd_beat: got g=%b d=%h v=%b want 1000/3D/1", grant, m_tdata, m_tvalid); end
    // Eight stalled cycles; port 0 starts requesting part-way through.
    for (int c = 2; c <= 9; c++) begin
      @(negedge clk);
      set_port(3, 8'h00, 1'b0, 1'b0);
      if (c >= 5) set_port(0, 8'h0A, 1'b1, 1'b1);
      #1;
      checks++; if (busy !== 1'b1 || grant !== 4'b1000) begin errors++; $display("FAIL wd_locked c%0d: got busy=%b g=%b want 1/1000", c, busy, grant); end
      checks++; if (tpulse !== 1'b0 || m_tvalid !== 1'b0) begin errors++; $display("FAIL wd_stall c%0d: got pulse=%b v=%b want 0/0", c, tpulse, m_tvalid); end
    end
    @(negedge clk); #1;
    checks++; if (tpulse !== 1'b1) begin errors++; $display("FAIL wd_pulse: got %b want 1", tpulse); end
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || m_tlast !== 1'b0) begin errors++; $display("FAIL wd_release: got g=%b busy=%b l=%b want 0000/0/0", grant, busy, m_tlast); end
    checks++; if (tpulse0 !== 1'b0 || busy0 !== 1'b1 || grant0 !== 4'b1000) begin errors++; $display("FAIL wd_disabled: got pulse=%b busy=%b g=%b want 0/1/1000", tpulse0, busy0, grant0); end
    @(negedge clk); #1;
    checks++; if (tpulse !== 1'b0) begin errors++; $display("FAIL wd_pulse_width: got %b want 0", tpulse); end
    checks++; if (grant !== 4'b0001 || m_tdata !== 8'h0A) begin errors++; $display("FAIL wd_next_port0: got g=%b d=%h want 0001/0A", grant, m_tdata); end
    clear_inputs();
  endtask

  task automatic test_tie_at_limit();
    apply_reset();
    set_port(1, 8'hE0, 1'b1, 1'b0);
    m_tready = 1'b1;
    #1;
    checks++; if (grant4 !== 4'b0000) begin errors++; $display("FAIL tie_idle: got %b want 0000", grant4); end
    @(negedge clk); #1;
    checks++; if (grant4 !== 4'b0010 || m_tdata4 !== 8'hE0) begin errors++; $display("FAIL tie_beat0: got g=%b d=%h want 0010/E0", grant4, m_tdata4); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      set_port(1, 8'hE1, 1'b1, 1'b1);
      m_tready = 1'b0;
      #1;
      checks++; if (busy4 !== 1'b1 || tpulse4 !== 1'b0 || s_tready4 !== 4'b0000) begin errors++; $display("FAIL tie_stall c%0d: got busy=%b pulse=%b rdy=%b want 1/0/0000", c, busy4, tpulse4, s_tready4); end
    end
    // Fourth stalled-count cycle: the tlast beat must beat the watchdog.
    @(negedge clk);
    m_tready = 1'b1;
    #1;
    checks++; if (m_tdata4 !== 8'hE1 || m_tlast4 !== 1'b1 || m_tvalid4 !== 1'b1) begin errors++; $display("FAIL tie_last: got d=%h l=%b v=%b want E1/1/1", m_tdata4, m_tlast4, m_tvalid4); end
    @(negedge clk);
    set_port(1, 8'hE2, 1'b1, 1'b0);
    #1;
    checks++; if (tpulse4 !== 1'b0) begin errors++; $display("FAIL tie_no_pulse: got %b want 0", tpulse4); end
    checks++; if (grant4 !== 4'b0000 || busy4 !== 1'b0) begin errors++; $display("FAIL tie_release: got g=%b busy=%b want 0000/0", grant4, busy4); end
    @(negedge clk); #1;
    checks++; if (grant4 !== 4'b0010 || m_tdata4 !== 8'hE2) begin errors++; $display("FAIL tie_regrant: got g=%b d=%h want 0010/E2", grant4, m_tdata4); end
    for (int c = 8; c <= 11; c++) begin
      @(negedge clk);
      set_port(1, 8'hE3, 1'b1, 1'b0);
      m_tready = 1'b0;
      #1;
      checks++; if (tpulse4 !== 1'b0 || busy4 !== 1'b1) begin errors++; $display("FAIL tie_stall2 c%0d: got pulse=%b busy=%b want 0/1", c, tpulse4, busy4); end
    end
    @(negedge clk); #1;
    checks++; if (tpulse4 !== 1'b1 || grant4 !== 4'b0000) begin errors++; $display("FAIL tie_timeout: got pulse=%b g=%b want 1/0000", tpulse4, grant4); end
    clear_inputs();
  endtask

  task automatic test_reset_mid_packet();
    apply_reset();
    set_port(1, 8'hF0, 1'b1, 1'b0);
    m_tready = 1'b1;
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0010 || m_tdata !== 8'hF0) begin errors++; $display("FAIL rmid_b1: got g=%b d=%h want 0010/F0", grant, m_tdata); end
    @(negedge clk);
    set_port(1, 8'hF1, 1'b1, 1'b0);
    #1;
    checks++; if (m_tdata !== 8'hF1 || m_tvalid !== 1'b1) begin errors++; $display("FAIL rmid_b2: got d=%h v=%b want F1/1", m_tdata, m_tvalid); end
    #1;
    rst_n = 1'b0;
    set_port(0, 8'h0B, 1'b1, 1'b1);
    #1;
    checks++; if (grant !== 4'b0000 || busy !== 1'b0 || tpulse !== 1'b0) begin errors++; $display("FAIL rmid_ctrl: got g=%b busy=%b pulse=%b want 0000/0/0", grant, busy, tpulse); end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || m_tdata !== 8'h00 || s_tready !== 4'b0000) begin errors++; $display("FAIL rmid_outs: got v=%b l=%b d=%h rdy=%b want 0/0/00/0000", m_tvalid, m_tlast, m_tdata, s_tready); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL rmid_no_residual: got %b want 0000", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 4'b0001 || m_tdata !== 8'h0B) begin errors++; $display("FAIL rmid_port0_first: got g=%b d=%h want 0001/0B", grant, m_tdata); end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got no finish want finish before 200000");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_round_robin();
    test_lock_backpressure();
    test_watchdog();
    test_tie_at_limit();
    test_reset_mid_packet();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
